// File: rtl/parity_stream_checker_pkg.sv
// Shared definitions for the parity stream checker: FSM codes, parity modes, error-counter width.
// The optional error counter is enabled by defining PARITY_ERR_COUNT_EN.
package parity_stream_checker_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  typedef struct packed {
    logic par_out;
    logic par_err;
  } par_result_t;

  // Parity bit the transmitter should have sent, given the data XOR and the mode.
  function automatic logic par_calc(input logic acc, input logic mode);
    return acc ^ mode;
  endfunction

endpackage

// File: rtl/parity_stream_checker_if.sv
// Stream and result signals of the parity stream checker.
// err_clr/err_cnt exist only when PARITY_ERR_COUNT_EN is defined.
interface parity_stream_checker_if #(
  parameter int unsigned CNT_W = 8
);
  import parity_stream_checker_pkg::*;

  logic             start;
  logic             odd_sel;
  logic             bit_valid;
  logic             bit_in;
  logic             busy;
  logic             done;
  logic             par_out;
  logic             par_err;
  logic [CNT_W-1:0] bit_cnt;
`ifdef PARITY_ERR_COUNT_EN
  logic                 err_clr;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output start, odd_sel, bit_valid, bit_in, err_clr,
    input  busy, done, par_out, par_err, bit_cnt, err_cnt
  );
  modport slave (
    input  start, odd_sel, bit_valid, bit_in, err_clr,
    output busy, done, par_out, par_err, bit_cnt, err_cnt
  );
`else
  modport master (
    output start, odd_sel, bit_valid, bit_in,
    input  busy, done, par_out, par_err, bit_cnt
  );
  modport slave (
    input  start, odd_sel, bit_valid, bit_in,
    output busy, done, par_out, par_err, bit_cnt
  );
`endif

endinterface

// File: rtl/parity_acc.sv
// One-bit XOR accumulator with synchronous clear (priority over enable) and async reset.
module parity_acc (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_bit,
  output logic o_acc
);

  logic r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_acc <= 1'b0;
    else if (i_clr) r_acc <= 1'b0;
    else if (i_en)  r_acc <= r_acc ^ i_bit;
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/parity_stream_checker.sv
// Serial parity checker: DATA_W data bits then one parity bit per frame, even/odd per frame.
// Define PARITY_ERR_COUNT_EN to add a saturating parity-error counter with synchronous clear.
module parity_stream_checker
  import parity_stream_checker_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input logic                     clk,
  input logic                     rst,
  parity_stream_checker_if.slave  bus
);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_mode;
  logic             r_busy;
  logic             r_done;
  par_result_t      r_res;
  logic             w_acc;
  logic             w_acc_clr;
  logic             w_acc_en;
  logic             w_last_bit;
  logic             w_par_take;

  assign w_last_bit = (r_bit_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_clr   = 1'b0;
    w_acc_en    = 1'b0;
    w_par_take  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_acc_clr   = 1'b1;
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.bit_valid) begin
          w_acc_en = 1'b1;
          if (w_last_bit) w_state_nxt = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (bus.bit_valid) begin
          w_par_take  = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  parity_acc u_acc (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_acc_clr),
    .i_en  (w_acc_en),
    .i_bit (bus.bit_in),
    .o_acc (w_acc)
  );

  // Status outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_mode    <= 1'b0;
      r_bit_cnt <= '0;
      r_res     <= '0;
    end else begin
      r_busy <= (w_state_nxt == ST_DATA) || (w_state_nxt == ST_PARITY);
      r_done <= (w_state_nxt == ST_DONE);
      if (w_acc_clr) begin
        r_mode    <= bus.odd_sel;
        r_bit_cnt <= '0;
      end else if (w_acc_en) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
      if (w_par_take) begin
        r_res.par_out <= par_calc(w_acc, r_mode);
        r_res.par_err <= bus.bit_in ^ par_calc(w_acc, r_mode);
      end
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.par_out = r_res.par_out;
  assign bus.par_err = r_res.par_err;
  assign bus.bit_cnt = r_bit_cnt;

`ifdef PARITY_ERR_COUNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // Counts erroring frames in the DONE cycle; clear wins, saturates instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_err_cnt <= '0;
    else if (bus.err_clr)       r_err_cnt <= '0;
    else if ((r_state == ST_DONE) && r_res.par_err && (r_err_cnt != ERR_CNT_MAX))
                                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
  end

  assign bus.err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_parity_stream_checker.sv
// Directed, table-driven bench for parity_stream_checker (DATA_W=8 and DATA_W=1 instances).
module tb_parity_stream_checker;
  import parity_stream_checker_pkg::*;

  localparam int unsigned CNT_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  parity_stream_checker_if #(.CNT_W(CNT_W)) bus8 ();
  parity_stream_checker_if #(.CNT_W(CNT_W)) bus1 ();

  parity_stream_checker #(.DATA_W(8), .CNT_W(CNT_W)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  parity_stream_checker #(.DATA_W(1), .CNT_W(CNT_W)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  typedef struct {
    logic       odd;
    logic [7:0] data;
    logic       pbit;
    logic       gap;
    logic       exp_out;
    logic       exp_err;
  } vec_t;

  vec_t vecs [7];
  int   checks = 0;
  int   passes = 0;
  int   exp_err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Full frame on the DATA_W=8 instance; start during gaps and during DONE must be ignored.
  task automatic frame8(input vec_t v, input bit chk, input bit clr_in_done);
    @(negedge clk);
    bus8.start = 1'b1; bus8.odd_sel = v.odd; bus8.bit_valid = 1'b1; bus8.bit_in = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0; bus8.bit_valid = 1'b0;
    if (chk) check("busy_after_start", 32'(bus8.busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (v.gap) begin
        bus8.bit_valid = 1'b0; bus8.start = 1'b1; bus8.odd_sel = ~v.odd;
        @(negedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
      end
      bus8.bit_valid = 1'b1; bus8.bit_in = v.data[i];
      @(negedge clk);
    end
    if (chk) begin
      check("bit_cnt_before_parity", 32'(bus8.bit_cnt), 32'd8);
      check("busy_in_parity", 32'(bus8.busy), 32'd1);
      check("no_early_done", 32'(bus8.done), 32'd0);
    end
    bus8.bit_valid = 1'b1; bus8.bit_in = v.pbit;
    @(negedge clk);
    bus8.bit_valid = 1'b0;
    if (chk) begin
      check("done_pulse", 32'(bus8.done), 32'd1);
      check("busy_in_done", 32'(bus8.busy), 32'd0);
      check("par_out", 32'(bus8.par_out), 32'(v.exp_out));
      check("par_err", 32'(bus8.par_err), 32'(v.exp_err));
      check("bit_cnt_done", 32'(bus8.bit_cnt), 32'd8);
    end
    bus8.start = 1'b1;
`ifdef PARITY_ERR_COUNT_EN
    bus8.err_clr = clr_in_done;
`endif
    if (clr_in_done) exp_err_cnt = 0;
    else if (v.exp_err && exp_err_cnt != 255) exp_err_cnt++;
    @(negedge clk);
    bus8.start = 1'b0;
`ifdef PARITY_ERR_COUNT_EN
    bus8.err_clr = 1'b0;
    if (chk) check("err_cnt", 32'(bus8.err_cnt), 32'(exp_err_cnt));
`endif
    if (chk) begin
      check("done_one_cycle", 32'(bus8.done), 32'd0);
      check("start_in_done_ignored", 32'(bus8.busy), 32'd0);
      check("par_out_held", 32'(bus8.par_out), 32'(v.exp_out));
    end
  endtask

  initial begin
    int   done_seen;
    vec_t v;

    vecs[0] = '{odd: 1'b0, data: 8'b1011_0010, pbit: 1'b0, gap: 1'b0, exp_out: 1'b0, exp_err: 1'b0};
    vecs[1] = '{odd: 1'b1, data: 8'b1011_0010, pbit: 1'b0, gap: 1'b0, exp_out: 1'b1, exp_err: 1'b1};
    vecs[2] = '{odd: 1'b0, data: 8'hFF,        pbit: 1'b0, gap: 1'b1, exp_out: 1'b0, exp_err: 1'b0};
    vecs[3] = '{odd: 1'b0, data: 8'hFF,        pbit: 1'b0, gap: 1'b0, exp_out: 1'b0, exp_err: 1'b0};
    vecs[4] = '{odd: 1'b1, data: 8'h01,        pbit: 1'b0, gap: 1'b0, exp_out: 1'b0, exp_err: 1'b0};
    vecs[5] = '{odd: 1'b0, data: 8'h07,        pbit: 1'b1, gap: 1'b1, exp_out: 1'b1, exp_err: 1'b0};
    vecs[6] = '{odd: 1'b1, data: 8'h00,        pbit: 1'b0, gap: 1'b0, exp_out: 1'b1, exp_err: 1'b1};

    rst = 1'b1;
    bus8.start = 1'b0; bus8.odd_sel = 1'b0; bus8.bit_valid = 1'b0; bus8.bit_in = 1'b0;
    bus1.start = 1'b0; bus1.odd_sel = 1'b0; bus1.bit_valid = 1'b0; bus1.bit_in = 1'b0;
`ifdef PARITY_ERR_COUNT_EN
    bus8.err_clr = 1'b0; bus1.err_clr = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus8.busy), 32'd0);
    check("rst_done", 32'(bus8.done), 32'd0);
    check("rst_par_out", 32'(bus8.par_out), 32'd0);
    check("rst_par_err", 32'(bus8.par_err), 32'd0);
    check("rst_bit_cnt", 32'(bus8.bit_cnt), 32'd0);
`ifdef PARITY_ERR_COUNT_EN
    check("rst_err_cnt", 32'(bus8.err_cnt), 32'd0);
`endif
    rst = 1'b0;

    // bit_valid without start in IDLE
    @(negedge clk);
    bus8.bit_valid = 1'b1; bus8.bit_in = 1'b1;
    @(negedge clk);
    bus8.bit_valid = 1'b0;
    check("idle_bit_ignored_cnt", 32'(bus8.bit_cnt), 32'd0);
    check("idle_bit_ignored_busy", 32'(bus8.busy), 32'd0);

    for (int i = 0; i < 7; i++) frame8(vecs[i], 1'b1, 1'b0);

    // Reset mid-frame after 4 data bits
    @(negedge clk);
    bus8.start = 1'b1; bus8.odd_sel = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus8.bit_valid = 1'b1; bus8.bit_in = 1'b1;
      @(negedge clk);
    end
    bus8.bit_valid = 1'b0;
    check("pre_rst_bit_cnt", 32'(bus8.bit_cnt), 32'd4);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(bus8.busy), 32'd0);
    check("midrst_bit_cnt", 32'(bus8.bit_cnt), 32'd0);
    check("midrst_par_err", 32'(bus8.par_err), 32'd0);
    exp_err_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.done) done_seen++;
    end
    check("midrst_no_done", 32'(done_seen), 32'd0);
    frame8(vecs[1], 1'b1, 1'b0);

    // DATA_W=1 instance: bit, parity, done
    @(negedge clk);
    bus1.start = 1'b1; bus1.odd_sel = PAR_EVEN;
    @(negedge clk);
    bus1.start = 1'b0; bus1.bit_valid = 1'b1; bus1.bit_in = 1'b1;
    check("w1_busy", 32'(bus1.busy), 32'd1);
    @(negedge clk);
    check("w1_in_parity_no_done", 32'(bus1.done), 32'd0);
    check("w1_bit_cnt", 32'(bus1.bit_cnt), 32'd1);
    bus1.bit_in = 1'b1;
    @(negedge clk);
    bus1.bit_valid = 1'b0;
    check("w1_done", 32'(bus1.done), 32'd1);
    check("w1_par_out", 32'(bus1.par_out), 32'd1);
    check("w1_par_err", 32'(bus1.par_err), 32'd0);
    @(negedge clk);
    check("w1_done_cleared", 32'(bus1.done), 32'd0);

`ifdef PARITY_ERR_COUNT_EN
    // Saturation, then clear colliding with an increment, then counting resumes
    v = vecs[6];
    for (int i = 0; i < 300; i++) frame8(v, 1'b0, 1'b0);
    check("err_cnt_saturated", 32'(bus8.err_cnt), 32'hFF);
    frame8(v, 1'b1, 1'b1);
    check("err_clr_wins", 32'(bus8.err_cnt), 32'd0);
    frame8(v, 1'b1, 1'b0);
`else
    v = vecs[0];
    frame8(v, 1'b1, 1'b0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
